cache_port_arbiter: RTL and testbench

- Shares the single fully-associative cache between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Grants one requester at a time and drives the cache address, data, read/write and chip-enable lines.
- Holds the request stable until the cache raises its output-data-valid, then returns read data with a one-cycle acknowledge.
- A watchdog aborts any access that never completes.

---
 rtl/cache_port_arbiter_if.sv | 49 ++++
 rtl/cache_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_cache_port_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-side signal bundle for cache_port_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever surrounds it.
interface cache_port_arbiter_if #(
    parameter int unsigned d_width = 8,
    parameter int unsigned a_width = 8
);
    logic               req0;
    logic               rw0;
    logic [a_width-1:0] addr0;
    logic [d_width-1:0] wdata0;
    logic [d_width-1:0] rdata0;
    logic               ack0;

    logic               req1;
    logic               rw1;
    logic [a_width-1:0] addr1;
    logic [d_width-1:0] wdata1;
    logic [d_width-1:0] rdata1;
    logic               ack1;

    logic [a_width-1:0] c_addr;
    logic [d_width-1:0] c_wdata;
    logic [d_width-1:0] c_rdata;
    logic               c_rw;
    logic               c_ce;
    logic               c_odv;

    logic               grant;
    logic               busy;
    logic               timeout_err;

    modport slave (
        input  req0, rw0, addr0, wdata0,
        input  req1, rw1, addr1, wdata1,
        input  c_rdata, c_odv,
        output rdata0, ack0, rdata1, ack1,
        output c_addr, c_wdata, c_rw, c_ce,
        output grant, busy, timeout_err
    );

    modport master (
        output req0, rw0, addr0, wdata0,
        output req1, rw1, addr1, wdata1,
        output c_rdata, c_odv,
        input  rdata0, ack0, rdata1, ack1,
        input  c_addr, c_wdata, c_rw, c_ce,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares one cache between instruction fetch (port 0) and load/store (port 1), with a WAIT watchdog.
// Define CACHE_ARB_RR_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module cache_port_arbiter #(
    parameter int unsigned d_width  = 8,
    parameter int unsigned a_width  = 8,
    parameter int unsigned max_wait = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    cache_port_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_GAP} state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [a_width-1:0] c_addr_q, c_addr_d;
    logic [d_width-1:0] c_wdata_q, c_wdata_d;
    logic [d_width-1:0] rdata0_q, rdata0_d;
    logic [d_width-1:0] rdata1_q, rdata1_d;
    logic               c_rw_q, c_rw_d;
    logic               c_ce_q, c_ce_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               busy_q, busy_d;
    logic               terr_q, terr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win;

    // Winner when the arbiter is ready to start a new access
`ifdef CACHE_ARB_RR_EN
    always_comb begin
        if (bus.req0 && bus.req1) win = ~last_q;
        else                      win = bus.req1;
    end
`else
    assign win = bus.req1;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        c_addr_d  = c_addr_q;
        c_wdata_d = c_wdata_q;
        c_rw_d    = c_rw_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        terr_d    = terr_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_d   = win;
                    c_addr_d  = win ? bus.addr1  : bus.addr0;
                    c_wdata_d = win ? bus.wdata1 : bus.wdata0;
                    c_rw_d    = win ? bus.rw1    : bus.rw0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Data-valid wins over the watchdog on the final allowed cycle
                if (bus.c_odv) begin
                    if (c_rw_q) begin
                        if (grant_q) rdata1_d = bus.c_rdata;
                        else         rdata0_d = bus.c_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(max_wait)) begin
                        terr_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs registered against the state being entered so they align with it
        c_ce_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
        busy_d = (state_d != S_IDLE);
        ack0_d = (state_d == S_DONE) && !grant_q;
        ack1_d = (state_d == S_DONE) &&  grant_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
            c_rw_q    <= 1'b1;
            c_ce_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            c_addr_q  <= c_addr_d;
            c_wdata_q <= c_wdata_d;
            c_rw_q    <= c_rw_d;
            c_ce_q    <= c_ce_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.c_addr      = c_addr_q;
    assign bus.c_wdata     = c_wdata_q;
    assign bus.c_rw        = c_rw_q;
    assign bus.c_ce        = c_ce_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a vector table of single accesses plus
// hand-written contention and mid-access reset sequences. Two instances (max_wait 15 and 4).
module tb_cache_port_arbiter;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
`ifdef CACHE_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct {
        bit         sel;
        bit         port;
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         dly;
        logic [7:0] rd;
        int         exp_lat;
        int         exp_ce;
        logic [7:0] exp_rdata;
        logic [7:0] exp_other;
        bit         exp_terr;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       sel = 1'b0;
    logic       req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       c_odv = 1'b0;
    logic [7:0] c_rdata = '0;
    int         n_chk, n_pass;
    vec_t       vecs[8];

    always #5 clk = ~clk;

    cache_port_arbiter_if #(.d_width(DW), .a_width(AW)) bus ();
    cache_port_arbiter_if #(.d_width(DW), .a_width(AW)) bus_t ();

    cache_port_arbiter #(.d_width(DW), .a_width(AW), .max_wait(15)) dut (
        .clk(clk), .clr(clr), .bus(bus));
    cache_port_arbiter #(.d_width(DW), .a_width(AW), .max_wait(4)) dut_t (
        .clk(clk), .clr(clr), .bus(bus_t));

    assign bus.req0     = ~sel & req0;
    assign bus.req1     = ~sel & req1;
    assign bus_t.req0   =  sel & req0;
    assign bus_t.req1   =  sel & req1;
    assign bus.rw0      = rw0;    assign bus_t.rw0    = rw0;
    assign bus.rw1      = rw1;    assign bus_t.rw1    = rw1;
    assign bus.addr0    = addr0;  assign bus_t.addr0  = addr0;
    assign bus.addr1    = addr1;  assign bus_t.addr1  = addr1;
    assign bus.wdata0   = wdata0; assign bus_t.wdata0 = wdata0;
    assign bus.wdata1   = wdata1; assign bus_t.wdata1 = wdata1;
    assign bus.c_odv    = c_odv;  assign bus_t.c_odv  = c_odv;
    assign bus.c_rdata  = c_rdata; assign bus_t.c_rdata = c_rdata;

    logic [7:0] m_rdata0, m_rdata1, m_c_addr, m_c_wdata;
    logic       m_ack0, m_ack1, m_c_rw, m_c_ce, m_grant, m_busy, m_terr;
    assign m_rdata0  = sel ? bus_t.rdata0      : bus.rdata0;
    assign m_rdata1  = sel ? bus_t.rdata1      : bus.rdata1;
    assign m_ack0    = sel ? bus_t.ack0        : bus.ack0;
    assign m_ack1    = sel ? bus_t.ack1        : bus.ack1;
    assign m_c_addr  = sel ? bus_t.c_addr      : bus.c_addr;
    assign m_c_wdata = sel ? bus_t.c_wdata     : bus.c_wdata;
    assign m_c_rw    = sel ? bus_t.c_rw        : bus.c_rw;
    assign m_c_ce    = sel ? bus_t.c_ce        : bus.c_ce;
    assign m_grant   = sel ? bus_t.grant       : bus.grant;
    assign m_busy    = sel ? bus_t.busy        : bus.busy;
    assign m_terr    = sel ? bus_t.timeout_err : bus.timeout_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; c_odv = 1'b0;
        #1 clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        tick();
    endtask

    // One access from an idle arbiter; requester inputs are scrambled once granted
    task automatic do_access(input vec_t v, output int lat, output int ce_n,
                             output bit stable, output bit clash, output bit ack_after);
        lat = 0; ce_n = 0; stable = 1'b1; clash = 1'b0;
        sel = v.sel; c_odv = 1'b0;
        if (v.port) begin rw1 = v.rw; addr1 = v.addr; wdata1 = v.wdata; req1 = 1'b1; end
        else        begin rw0 = v.rw; addr0 = v.addr; wdata0 = v.wdata; req0 = 1'b1; end
        for (int e = 1; e <= 40; e++) begin
            tick();
            c_odv = 1'b0;
            if (m_ack0 && m_ack1) clash = 1'b1;
            if (v.port ? m_ack0 : m_ack1) clash = 1'b1;
            if (v.port ? m_ack1 : m_ack0) begin lat = e; break; end
            if (m_c_ce) begin
                ce_n++;
                if (m_c_addr !== v.addr || m_c_rw !== v.rw || m_c_wdata !== v.wdata) stable = 1'b0;
                if (ce_n == 1) begin
                    if (v.port) begin addr1 = ~v.addr; wdata1 = ~v.wdata; rw1 = ~v.rw; end
                    else        begin addr0 = ~v.addr; wdata0 = ~v.wdata; rw0 = ~v.rw; end
                end
                if (v.dly >= 0 && ce_n == v.dly + 2) begin c_odv = 1'b1; c_rdata = v.rd; end
            end
        end
        req0 = 1'b0; req1 = 1'b0; c_odv = 1'b0;
        tick();
        ack_after = m_ack0 | m_ack1;
        tick();
    endtask

    // Both ports request together; each drops its request on its own ack
    task automatic contend(output int first, output int second, output int gap, output bit clash);
        int n, t_first;
        first = -1; second = -1; gap = 0; clash = 1'b0; n = 0; t_first = 0;
        sel = 1'b0; rw0 = 1'b1; rw1 = 1'b1; addr0 = 8'h10; addr1 = 8'h11;
        wdata0 = '0; wdata1 = '0; c_odv = 1'b1; c_rdata = 8'h60;
        req0 = 1'b1; req1 = 1'b1;
        for (int e = 1; e <= 30 && n < 2; e++) begin
            tick();
            if (m_ack0 && m_ack1) clash = 1'b1;
            if (m_ack0 || m_ack1) begin
                if (n == 0) begin first = m_ack1 ? 1 : 0; t_first = e; end
                else begin second = m_ack1 ? 1 : 0; gap = e - t_first; end
                n++;
                if (m_ack0) req0 = 1'b0;
                if (m_ack1) req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0; c_odv = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat, ce_n, first, second, gap;
        bit  stable, clash, ack_after;
        n_chk = 0; n_pass = 0;

        // sel port rw addr wdata dly rd | lat ce rdata other terr
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h00,  0, 8'hA5,  3,  2, 8'hA5, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h40, 8'h3C,  0, 8'h77,  3,  2, 8'h00, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h00,  8, 8'h5E, 11, 10, 8'h5E, 8'hA5, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h20, 8'hC3,  2, 8'hFF,  5,  4, 8'hA5, 8'h5E, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 14, 8'h01, 17, 16, 8'h01, 8'h5E, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h33, 8'h00,  0, 8'h9A,  3,  2, 8'h9A, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h34, 8'h00, -1, 8'hEE,  6,  5, 8'h9A, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h35, 8'h00,  3, 8'h4B,  6,  5, 8'h4B, 8'h9A, 1'b1};

        do_reset();
        chk("rst_c_ce", m_c_ce, 0);
        chk("rst_c_rw", m_c_rw, 1);
        chk("rst_c_addr", m_c_addr, 0);
        chk("rst_c_wdata", m_c_wdata, 0);
        chk("rst_grant", m_grant, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_terr", m_terr, 0);
        chk("rst_ack0", m_ack0, 0);
        chk("rst_ack1", m_ack1, 0);
        chk("rst_rdata0", m_rdata0, 0);
        chk("rst_rdata1", m_rdata1, 0);

        // Stray data-valid while idle
        c_odv = 1'b1; c_rdata = 8'hBD;
        tick(); tick();
        chk("odv_idle_busy", m_busy, 0);
        chk("odv_idle_ack0", m_ack0, 0);
        chk("odv_idle_rdata0", m_rdata0, 0);
        c_odv = 1'b0;

        for (int p = 0; p < 2; p++) begin
            contend(first, second, gap, clash);
            chk($sformatf("cont%0d_first", p), first, RR_MODE ? 0 : 1);
            chk($sformatf("cont%0d_second", p), second, RR_MODE ? 1 : 0);
            chk($sformatf("cont%0d_gap", p), gap, 5);
            chk($sformatf("cont%0d_clash", p), clash, 0);
        end
        chk("cont_rdata0", m_rdata0, 8'h60);
        chk("cont_rdata1", m_rdata1, 8'h60);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i], lat, ce_n, stable, clash, ack_after);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_ce_cycles", i), ce_n, vecs[i].exp_ce);
            chk($sformatf("v%0d_stable", i), stable, 1);
            chk($sformatf("v%0d_clash", i), clash, 0);
            chk($sformatf("v%0d_ack_len", i), ack_after, 0);
            chk($sformatf("v%0d_rdata", i), vecs[i].port ? m_rdata1 : m_rdata0, vecs[i].exp_rdata);
            chk($sformatf("v%0d_rdata_other", i), vecs[i].port ? m_rdata0 : m_rdata1, vecs[i].exp_other);
            chk($sformatf("v%0d_terr", i), m_terr, vecs[i].exp_terr);
            chk($sformatf("v%0d_grant", i), m_grant, vecs[i].port);
            chk($sformatf("v%0d_busy_end", i), m_busy, 0);
        end

        // Reset asserted between edges while an access is in WAIT
        sel = 1'b0; c_odv = 1'b0; rw0 = 1'b1; addr0 = 8'h55; wdata0 = '0; req0 = 1'b1;
        tick(); tick();
        chk("mid_ce_before", m_c_ce, 1);
        #2 clr = 1'b0;
        #1;
        chk("mid_ce_async", m_c_ce, 0);
        chk("mid_busy_async", m_busy, 0);
        tick();
        chk("mid_no_ack", m_ack0, 0);
        @(negedge clk);
        clr = 1'b1; c_odv = 1'b1; c_rdata = 8'h2D;
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) chk("mid_restart_ce", m_c_ce, 1);
            if (m_ack0) begin lat = e; break; end
        end
        chk("mid_restart_lat", lat, 3);
        chk("mid_restart_rdata0", m_rdata0, 8'h2D);
        req0 = 1'b0; c_odv = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
